mult32x32_fsm: RTL
==================

Name: mult32x32_fsm

Overview:
- Sequencing controller for the 32x32 shift-add multiplier arithmetic unit.
- Accepts a start request and drives the arith unit's a_sel, b_sel, shift_sel, upd_prod and clr_prod. It clears the product register, then accumulates all eight 8x16 partial products, one per cycle.
- Reports busy/done to the requester.
- Sits beside the arith unit inside the mult32x32 top level. Operands a and b go straight to the arith unit; the requester must hold them stable while busy=1.

Parameters:
- none: fixed 32x32 geometry, 4 A-bytes x 2 B-halves = 8 steps.

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-low reset: reset==0 at a rising edge resets the block
- start  input  1  begin a multiplication; sampled only in IDLE or DONE
- abort  input  1  cancel the operation in progress; sampled in CLR/ACC
- busy  output  1  high in CLR and ACC
- done  output  1  one-cycle pulse; product is final in this cycle
- a_sel  output  2  A-byte select to the arith unit
- b_sel  output  1  B-halfword select to the arith unit
- shift_sel  output  3  shifter select to the arith unit
- upd_prod  output  1  product register update enable
- clr_prod  output  1  product register clear

Behaviour:
- States: IDLE, CLR, ACC, DONE. A 3-bit step counter k is used in ACC.
- All outputs are Moore, decoded from the state register and k. There are no combinational paths from inputs to outputs.
- Reset (reset==0 at an edge): state=IDLE, k=0. Outputs: busy=0, done=0, a_sel=0, b_sel=0, shift_sel=0, upd_prod=0, clr_prod=0. Reset overrides start and abort in any state, including mid-operation; no done pulse follows.
- IDLE: all outputs 0. start=1 -> CLR.
- CLR (1 cycle):
  - clr_prod=1, busy=1, upd_prod=0.
  - abort=1 -> IDLE; else -> ACC with k=0.
- ACC (8 cycles, k=0..7):
  - busy=1, upd_prod=1, clr_prod=0.
  - a_sel=k[1:0], b_sel=k[2], shift_sel=a_sel+2*b_sel. This is an 8*a_sel+16*b_sel bit shift, so shift_sel stays in the range 0..5.
  - Step order:
    - k=0..3 -> (a_sel,b_sel,shift_sel) = (0,0,0), (1,0,1), (2,0,2), (3,0,3)
    - k=4..7 -> (0,1,2), (1,1,3), (2,1,4), (3,1,5)
  - k increments every cycle. At k=7 -> DONE.
  - abort=1 in any ACC cycle -> IDLE next edge. upd_prod is still 1 in that cycle, because outputs are Moore; the product is partial and no done pulse follows.
- DONE (1 cycle):
  - done=1, busy=0, upd_prod=0, clr_prod=0, selects 0.
  - start=1 -> CLR (back-to-back operation); else -> IDLE.
- Latency: start seen at edge of cycle 0 -> CLR in cycle 1 -> ACC in cycles 2..9 -> done=1 in cycle 10, with product final. Throughput is one multiply per 10 cycles with start held.
- Simultaneous events:
  - start while busy=1 is ignored.
  - abort in IDLE or DONE is ignored.
  - Reset has the highest priority, then abort, then normal sequencing.
- Invariants, checked by assertions:
  - upd_prod and clr_prod are never both 1.
  - shift_sel is never 6 or 7.
  - done and busy are never both 1.
  - done is never high for two consecutive cycles unless separated by a full operation.
- Integration: the top level drives the arith unit's active-high reset from ~reset.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, then release with start=0 -> all outputs 0 and remain 0 for 20 cycles.
- Basic sequence with the arith unit: a=0x12345678, b=0x9ABCDEF0, start pulse -> busy=1 for cycles 1..9, clr_prod=1 in cycle 1. The exact (a_sel,b_sel,shift_sel) order above appears in cycles 2..9. done=1 in cycle 10 with product=0x0B00EA4E242D2080.
- Corner values: a=b=0xFFFFFFFF -> product=0xFFFFFFFE00000001 at done. Then a=0, b=0xFFFFFFFF -> product=0 (CLR verified).
- Back-to-back: start held high continuously -> done pulses in cycles 10, 20, 30. CLR follows DONE directly, with no IDLE cycle.
- Abort at ACC k=3 -> IDLE next cycle, no done, busy=0. A new start gives the correct product 10 cycles later.
- Reset mid-ACC (k=5): reset=0 for one edge -> IDLE immediately, upd_prod=0 next cycle, no done. start during busy (cycle 4) is ignored, and done still comes at cycle 10 only.

Source files
------------

// File: rtl/mult32x32_fsm.sv
// mult32x32_fsm -- sequencing controller for the 32x32 shift-add multiplier.
//
// Clears the product register for one cycle, then walks the eight 8x16
// partial products (4 A-bytes x 2 B-halfwords), one per cycle, and pulses
// done when the product is final. All outputs are registered and decoded
// from the next state, so they are pure functions of (state, k).
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-low reset
//   start      in   begin a multiply (honoured in IDLE or DONE)
//   abort      in   cancel in-flight multiply (honoured in CLR or ACC)
//   busy       out  high in CLR and ACC
//   done       out  one-cycle pulse, product final
//   a_sel      out  A-byte select
//   b_sel      out  B-halfword select
//   shift_sel  out  shifter select, shift = 8*shift_sel bits (0..5)
//   upd_prod   out  product register accumulate enable
//   clr_prod   out  product register clear
module mult32x32_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [1:0] a_sel,
  output logic       b_sel,
  output logic [2:0] shift_sel,
  output logic       upd_prod,
  output logic       clr_prod
);

  typedef enum logic [1:0] {IDLE, CLR, ACC, DONE} state_t;

  state_t     state, nxt_state;
  logic [2:0] k, nxt_k;

  // Next-state: abort outranks normal sequencing; start only acts when idle
  // or finishing, which gives back-to-back DONE -> CLR with start held.
  always_comb begin
    nxt_state = state;
    nxt_k     = k;
    case (state)
      IDLE: if (start) nxt_state = CLR;
      CLR: begin
        nxt_k = 3'd0;
        nxt_state = abort ? IDLE : ACC;
      end
      ACC: begin
        if (abort)          nxt_state = IDLE;
        else if (k == 3'd7) nxt_state = DONE;
        else                nxt_k = k + 3'd1;
      end
      DONE: nxt_state = start ? CLR : IDLE;
      default: nxt_state = IDLE;
    endcase
    if (nxt_state != ACC) nxt_k = 3'd0;
  end

  // State and outputs registered together; outputs decode the next state so
  // they line up with the state register without input-to-output paths.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      k         <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      a_sel     <= 2'd0;
      b_sel     <= 1'b0;
      shift_sel <= 3'd0;
      upd_prod  <= 1'b0;
      clr_prod  <= 1'b0;
    end else begin
      state    <= nxt_state;
      k        <= nxt_k;
      busy     <= (nxt_state == CLR) || (nxt_state == ACC);
      done     <= (nxt_state == DONE);
      clr_prod <= (nxt_state == CLR);
      upd_prod <= (nxt_state == ACC);
      if (nxt_state == ACC) begin
        a_sel     <= nxt_k[1:0];
        b_sel     <= nxt_k[2];
        // 8*a_sel + 16*b_sel bits, expressed in byte units
        shift_sel <= {1'b0, nxt_k[1:0]} + {1'b0, nxt_k[2], 1'b0};
      end else begin
        a_sel     <= 2'd0;
        b_sel     <= 1'b0;
        shift_sel <= 3'd0;
      end
    end
  end

  // Output invariants
  a_upd_clr_excl: assert property (@(posedge clk) disable iff (!reset)
    !(upd_prod && clr_prod));
  a_shift_range:  assert property (@(posedge clk) disable iff (!reset)
    shift_sel <= 3'd5);
  a_done_busy:    assert property (@(posedge clk) disable iff (!reset)
    !(done && busy));
  a_done_pulse:   assert property (@(posedge clk) disable iff (!reset)
    !(done && $past(done)));

endmodule
